// File: rtl/job_pe_mesh_port_if.sv
// rtl/job_pe_mesh_port_if.sv - request/packet/response handshake bundle for job_pe_mesh_port
interface job_pe_mesh_port_if #(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 3,
  parameter int MLEN_W = 6,
  parameter int X_W    = 2,
  parameter int Y_W    = 2,
  parameter int MESH_W = 80
);
  // job PE request channel
  logic              match_req_valid;
  logic              match_req_ready;
  logic [ADDR_W-1:0] match_req_head_addr;
  logic [ADDR_W-1:0] match_req_history_addr;
  logic [TAG_W-1:0]  match_req_tag;
  // outbound mesh packet channel
  logic              to_mesh_valid;
  logic              to_mesh_ready;
  logic [X_W-1:0]    to_mesh_x_dst;
  logic [Y_W-1:0]    to_mesh_y_dst;
  logic [MESH_W-1:0] to_mesh_payload;
  // inbound mesh response channel
  logic              from_mesh_valid;
  logic              from_mesh_ready;
  logic [MESH_W-1:0] from_mesh_payload;
  // job PE response channel
  logic              match_resp_valid;
  logic              match_resp_ready;
  logic [TAG_W-1:0]  match_resp_tag;
  logic [MLEN_W-1:0] match_resp_match_len;

  // adapter side
  modport slave (
    input  match_req_valid, match_req_head_addr, match_req_history_addr, match_req_tag,
    output match_req_ready,
    output to_mesh_valid, to_mesh_x_dst, to_mesh_y_dst, to_mesh_payload,
    input  to_mesh_ready,
    input  from_mesh_valid, from_mesh_payload,
    output from_mesh_ready,
    output match_resp_valid, match_resp_tag, match_resp_match_len,
    input  match_resp_ready
  );

  // job PE plus mesh side
  modport master (
    output match_req_valid, match_req_head_addr, match_req_history_addr, match_req_tag,
    input  match_req_ready,
    input  to_mesh_valid, to_mesh_x_dst, to_mesh_y_dst, to_mesh_payload,
    output to_mesh_ready,
    output from_mesh_valid, from_mesh_payload,
    input  from_mesh_ready,
    input  match_resp_valid, match_resp_tag, match_resp_match_len,
    output match_resp_ready
  );
endinterface

// File: rtl/job_pe_mesh_port.sv
// rtl/job_pe_mesh_port.sv - job PE to shared match PE mesh adapter with tag tracking
module job_pe_mesh_port #(
  parameter int JOB_PE_IDX      = 0,
  parameter int ADDR_W          = 32,
  parameter int TAG_W           = 3,
  parameter int MLEN_W          = 6,
  parameter int PE_IDX_W        = 3,
  parameter int X_W             = 2,
  parameter int Y_W             = 2,
  parameter int LOCAL_ADDR_W    = 13,
  parameter int MESH_W          = 80,
  parameter int MAX_OUTSTANDING = 4,
  parameter int INTERLEAVE      = 1
) (
  input  logic             clk,
  input  logic             rst,
  job_pe_mesh_port_if.slave bus,
  output logic [TAG_W:0]   outstanding_cnt,
  output logic             idle,
  output logic             err_unexpected_tag
);

  localparam int NTAGS = 1 << TAG_W;
  localparam int MAP_W = X_W + Y_W - INTERLEAVE;
  localparam int PKT_W = 2 * ADDR_W + TAG_W + PE_IDX_W;
  localparam logic [TAG_W:0] MAX_CNT = (TAG_W + 1)'(MAX_OUTSTANDING);
  localparam logic [TAG_W:0] CNT_ONE = (TAG_W + 1)'(1);
  localparam logic [PE_IDX_W-1:0] PE_IDX = PE_IDX_W'(JOB_PE_IDX);

  // request ping-pong buffer
  logic [ADDR_W-1:0] req_head_q [2];
  logic [ADDR_W-1:0] req_head_d [2];
  logic [ADDR_W-1:0] req_hist_q [2];
  logic [ADDR_W-1:0] req_hist_d [2];
  logic [TAG_W-1:0]  req_tag_q  [2];
  logic [TAG_W-1:0]  req_tag_d  [2];
  logic [X_W-1:0]    req_x_q    [2];
  logic [X_W-1:0]    req_x_d    [2];
  logic [Y_W-1:0]    req_y_q    [2];
  logic [Y_W-1:0]    req_y_d    [2];
  logic              req_wr_q, req_wr_d;
  logic              req_rd_q, req_rd_d;
  logic [1:0]        req_fill_q, req_fill_d;

  // response ping-pong buffer
  logic [TAG_W-1:0]  resp_tag_q [2];
  logic [TAG_W-1:0]  resp_tag_d [2];
  logic [MLEN_W-1:0] resp_len_q [2];
  logic [MLEN_W-1:0] resp_len_d [2];
  logic              resp_wr_q, resp_wr_d;
  logic              resp_rd_q, resp_rd_d;
  logic [1:0]        resp_fill_q, resp_fill_d;

  // tag tracking and status
  logic [NTAGS-1:0]  inflight_q, inflight_d;
  logic [TAG_W:0]    cnt_q, cnt_d;
  logic              err_q, err_d;

  // handshake decodes
  logic              req_ready;
  logic              req_fire;
  logic              mesh_fire;
  logic              rsp_ready;
  logic              rsp_fire;
  logic              rsp_hit;
  logic              rsp_miss;
  logic              deliver;
  logic [TAG_W-1:0]  in_tag;
  logic [MLEN_W-1:0] in_len;

  // destination mapping
  logic [MAP_W-1:0]  map_sel;
  logic [X_W-1:0]    map_x;
  logic [Y_W-1:0]    map_y;
  logic [MESH_W-1:0] pkt_payload;
  logic              unused_payload_bits;

  assign map_sel = bus.match_req_history_addr[LOCAL_ADDR_W +: MAP_W];
  assign map_x   = map_sel[X_W-1:0];

  // interleaved shared PEs sit on odd rows, so the lowest y bit is forced to 1
  generate
    if (INTERLEAVE != 0) begin : g_interleave
      assign map_y = {map_sel[MAP_W-1 -: Y_W-1], 1'b1};
    end else begin : g_dense
      assign map_y = map_sel[MAP_W-1 -: Y_W];
    end
  endgenerate

  // only {match_len, tag} of the response payload carry information
  assign in_tag = bus.from_mesh_payload[TAG_W-1:0];
  assign in_len = bus.from_mesh_payload[TAG_W +: MLEN_W];
  assign unused_payload_bits = ^bus.from_mesh_payload[MESH_W-1:TAG_W+MLEN_W];

  // acceptance terms use registered state only, so no ready-to-ready path exists
  assign req_ready = (req_fill_q != 2'd2) && (cnt_q < MAX_CNT) && !inflight_q[bus.match_req_tag];
  assign req_fire  = bus.match_req_valid && req_ready;
  assign mesh_fire = (req_fill_q != 2'd0) && bus.to_mesh_ready;
  assign rsp_ready = (resp_fill_q != 2'd2);
  assign rsp_fire  = bus.from_mesh_valid && rsp_ready;
  assign rsp_hit   = rsp_fire && inflight_q[in_tag];
  assign rsp_miss  = rsp_fire && !inflight_q[in_tag];
  assign deliver   = (resp_fill_q != 2'd0) && bus.match_resp_ready;

  // next-state for both buffers, the tag bitmap, the count and the error flag
  always_comb begin
    req_head_d  = req_head_q;
    req_hist_d  = req_hist_q;
    req_tag_d   = req_tag_q;
    req_x_d     = req_x_q;
    req_y_d     = req_y_q;
    req_wr_d    = req_wr_q;
    req_rd_d    = req_rd_q;
    req_fill_d  = req_fill_q;
    resp_tag_d  = resp_tag_q;
    resp_len_d  = resp_len_q;
    resp_wr_d   = resp_wr_q;
    resp_rd_d   = resp_rd_q;
    resp_fill_d = resp_fill_q;
    inflight_d  = inflight_q;
    cnt_d       = cnt_q;
    err_d       = err_q | rsp_miss;

    if (req_fire) begin
      req_head_d[req_wr_q] = bus.match_req_head_addr;
      req_hist_d[req_wr_q] = bus.match_req_history_addr;
      req_tag_d[req_wr_q]  = bus.match_req_tag;
      req_x_d[req_wr_q]    = map_x;
      req_y_d[req_wr_q]    = map_y;
      req_wr_d             = ~req_wr_q;
    end
    if (mesh_fire) begin
      req_rd_d = ~req_rd_q;
    end
    case ({req_fire, mesh_fire})
      2'b10:   req_fill_d = req_fill_q + 2'd1;
      2'b01:   req_fill_d = req_fill_q - 2'd1;
      default: req_fill_d = req_fill_q;
    endcase

    if (rsp_hit) begin
      resp_tag_d[resp_wr_q] = in_tag;
      resp_len_d[resp_wr_q] = in_len;
      resp_wr_d             = ~resp_wr_q;
    end
    if (deliver) begin
      resp_rd_d = ~resp_rd_q;
    end
    case ({rsp_hit, deliver})
      2'b10:   resp_fill_d = resp_fill_q + 2'd1;
      2'b01:   resp_fill_d = resp_fill_q - 2'd1;
      default: resp_fill_d = resp_fill_q;
    endcase

    // retire before set: a same-cycle request tag was free in the old bitmap,
    // so it can never equal the retiring tag
    if (rsp_hit) begin
      inflight_d[in_tag] = 1'b0;
    end
    if (req_fire) begin
      inflight_d[bus.match_req_tag] = 1'b1;
    end
    case ({req_fire, rsp_hit})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // control state with synchronous reset; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      req_wr_q    <= 1'b0;
      req_rd_q    <= 1'b0;
      req_fill_q  <= 2'd0;
      resp_wr_q   <= 1'b0;
      resp_rd_q   <= 1'b0;
      resp_fill_q <= 2'd0;
      inflight_q  <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      req_wr_q    <= req_wr_d;
      req_rd_q    <= req_rd_d;
      req_fill_q  <= req_fill_d;
      resp_wr_q   <= resp_wr_d;
      resp_rd_q   <= resp_rd_d;
      resp_fill_q <= resp_fill_d;
      inflight_q  <= inflight_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  // buffer payload storage; contents only matter when the fill count says so
  always_ff @(posedge clk) begin
    req_head_q <= req_head_d;
    req_hist_q <= req_hist_d;
    req_tag_q  <= req_tag_d;
    req_x_q    <= req_x_d;
    req_y_q    <= req_y_d;
    resp_tag_q <= resp_tag_d;
    resp_len_q <= resp_len_d;
  end

  // mesh packet layout: {zero pad, head, history, tag, job PE index}
  always_comb begin
    pkt_payload = '0;
    pkt_payload[PKT_W-1:0] = {req_head_q[req_rd_q], req_hist_q[req_rd_q], req_tag_q[req_rd_q], PE_IDX};
  end

  assign bus.match_req_ready      = req_ready;
  assign bus.to_mesh_valid        = (req_fill_q != 2'd0);
  assign bus.to_mesh_x_dst        = req_x_q[req_rd_q];
  assign bus.to_mesh_y_dst        = req_y_q[req_rd_q];
  assign bus.to_mesh_payload      = pkt_payload;
  assign bus.from_mesh_ready      = rsp_ready;
  assign bus.match_resp_valid     = (resp_fill_q != 2'd0);
  assign bus.match_resp_tag       = resp_tag_q[resp_rd_q];
  assign bus.match_resp_match_len = resp_len_q[resp_rd_q];

  assign outstanding_cnt    = cnt_q;
  assign idle               = (cnt_q == '0) && (req_fill_q == 2'd0) && (resp_fill_q == 2'd0);
  assign err_unexpected_tag = err_q;

endmodule

// File: tb/tb_job_pe_mesh_port.sv
// tb/tb_job_pe_mesh_port.sv - scoreboard bench for job_pe_mesh_port
module tb_job_pe_mesh_port;
  localparam int ADDR_W = 32;
  localparam int TAG_W = 3;
  localparam int MLEN_W = 6;
  localparam int PE_IDX_W = 3;
  localparam int X_W = 2;
  localparam int Y_W = 2;
  localparam int LOCAL_ADDR_W = 13;
  localparam int MESH_W = 80;
  localparam int MAX_OUT = 4;
  localparam int PE_IDX = 5;
  localparam int W = MESH_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  job_pe_mesh_port_if #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .MLEN_W(MLEN_W), .X_W(X_W), .Y_W(Y_W), .MESH_W(MESH_W)) bus0();
  job_pe_mesh_port_if #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .MLEN_W(MLEN_W), .X_W(X_W), .Y_W(Y_W), .MESH_W(MESH_W)) bus1();

  logic [TAG_W:0] cnt0, cnt1;
  logic idle0, idle1, err0, err1;

  job_pe_mesh_port #(.JOB_PE_IDX(PE_IDX), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .MLEN_W(MLEN_W), .PE_IDX_W(PE_IDX_W),
    .X_W(X_W), .Y_W(Y_W), .LOCAL_ADDR_W(LOCAL_ADDR_W), .MESH_W(MESH_W), .MAX_OUTSTANDING(MAX_OUT), .INTERLEAVE(1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .outstanding_cnt(cnt0), .idle(idle0), .err_unexpected_tag(err0));

  job_pe_mesh_port #(.JOB_PE_IDX(PE_IDX), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .MLEN_W(MLEN_W), .PE_IDX_W(PE_IDX_W),
    .X_W(X_W), .Y_W(Y_W), .LOCAL_ADDR_W(LOCAL_ADDR_W), .MESH_W(MESH_W), .MAX_OUTSTANDING(MAX_OUT), .INTERLEAVE(0)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .outstanding_cnt(cnt1), .idle(idle1), .err_unexpected_tag(err1));

  typedef struct {
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [MESH_W-1:0] payload;
  } pkt_t;

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [MLEN_W-1:0] len;
  } resp_t;

  pkt_t  exp_pkt[$];
  resp_t exp_resp[$];
  pkt_t  mon_p;
  resp_t mon_r;

  int n_checks = 0;
  int n_fail = 0;

  bit m_inflight[8];
  int m_cnt;
  bit m_err;
  bit strict_ready;
  bit req_fired;
  bit resp_fired;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // expected packet from the address-mapping rules, using plain arithmetic on the shared PE number
  function automatic pkt_t model_pkt(input logic [31:0] head, input logic [31:0] hist, input logic [2:0] tag, input bit interleave);
    pkt_t p;
    int unsigned shared_idx;
    if (interleave) begin
      shared_idx = (hist >> LOCAL_ADDR_W) % 8;
      p.x = 2'(shared_idx % 4);
      p.y = 2'((shared_idx / 4) * 2 + 1);
    end else begin
      shared_idx = (hist >> LOCAL_ADDR_W) % 16;
      p.x = 2'(shared_idx % 4);
      p.y = 2'(shared_idx / 4);
    end
    p.payload = {16'd0, head, hist, tag, 3'(PE_IDX)};
    return p;
  endfunction

  function automatic logic [W-1:0] make_resp(input logic [2:0] tag, input logic [5:0] len);
    logic [W-1:0] pl;
    pl = {16'($urandom), $urandom, $urandom};
    pl[2:0] = tag;
    pl[8:3] = len;
    return pl;
  endfunction

  // monitor: compare every outbound packet and delivered response against the queues
  always @(negedge clk) begin
    if (!rst) begin
      if (bus0.to_mesh_valid && bus0.to_mesh_ready) begin
        if (exp_pkt.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pkt_unexpected: got packet %0h expected none", bus0.to_mesh_payload);
        end else begin
          mon_p = exp_pkt.pop_front();
          chk("pkt_x", W'(bus0.to_mesh_x_dst), W'(mon_p.x));
          chk("pkt_y", W'(bus0.to_mesh_y_dst), W'(mon_p.y));
          chk("pkt_payload", bus0.to_mesh_payload, mon_p.payload);
        end
      end
      if (bus0.match_resp_valid && bus0.match_resp_ready) begin
        if (exp_resp.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL resp_unexpected: got tag %0d expected none", bus0.match_resp_tag);
        end else begin
          mon_r = exp_resp.pop_front();
          chk("resp_tag", W'(bus0.match_resp_tag), W'(mon_r.tag));
          chk("resp_len", W'(bus0.match_resp_match_len), W'(mon_r.len));
        end
      end
    end
  end

  // one cycle of dut0: check registered status, then update the model from what fired
  task automatic tick();
    bit ok;
    logic [2:0] t;
    @(negedge clk);
    chk("outstanding_cnt", W'(cnt0), W'(m_cnt));
    chk("err_unexpected_tag", W'(err0), W'(m_err));
    req_fired = 0;
    resp_fired = 0;
    ok = (m_cnt < MAX_OUT) && !m_inflight[bus0.match_req_tag];
    if (bus0.match_req_valid) begin
      if (!ok) chk("req_ready_blocked", W'(bus0.match_req_ready), W'(0));
      else if (strict_ready) chk("req_ready_open", W'(bus0.match_req_ready), W'(1));
      req_fired = bus0.match_req_ready;
    end
    if (bus0.from_mesh_valid && bus0.from_mesh_ready) begin
      resp_fired = 1;
      t = bus0.from_mesh_payload[2:0];
      if (m_inflight[t]) begin
        m_inflight[t] = 0;
        m_cnt--;
        exp_resp.push_back('{t, bus0.from_mesh_payload[8:3]});
      end else begin
        m_err = 1;
      end
    end
    if (req_fired) begin
      m_inflight[bus0.match_req_tag] = 1;
      m_cnt++;
      exp_pkt.push_back(model_pkt(bus0.match_req_head_addr, bus0.match_req_history_addr, bus0.match_req_tag, 1'b1));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_resp(input logic [2:0] tag, input logic [5:0] len);
    bit done;
    done = 0;
    bus0.from_mesh_valid = 1'b1;
    bus0.from_mesh_payload = make_resp(tag, len);
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      done = resp_fired;
    end
    if (!done) chk("resp_accept_timeout", W'(0), W'(1));
    bus0.from_mesh_valid = 1'b0;
  endtask

  task automatic set_req(input bit v, input logic [2:0] tag, input logic [31:0] head, input logic [31:0] hist);
    bus0.match_req_valid = v;
    bus0.match_req_tag = tag;
    bus0.match_req_head_addr = head;
    bus0.match_req_history_addr = hist;
  endtask

  task automatic do_reset();
    set_req(1'b0, 3'd0, 32'd0, 32'd0);
    bus0.to_mesh_ready = 1'b0;
    bus0.from_mesh_valid = 1'b0;
    bus0.match_resp_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) m_inflight[i] = 0;
    m_cnt = 0;
    m_err = 0;
    exp_pkt.delete();
    exp_resp.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cand[$];
    logic [2:0] t;
    bit done;
    pkt_t e1;

    bus1.match_req_valid = 1'b0;
    bus1.match_req_tag = '0;
    bus1.match_req_head_addr = '0;
    bus1.match_req_history_addr = '0;
    bus1.to_mesh_ready = 1'b1;
    bus1.from_mesh_valid = 1'b0;
    bus1.from_mesh_payload = '0;
    bus1.match_resp_ready = 1'b1;
    bus0.from_mesh_payload = '0;
    strict_ready = 1;
    do_reset();
    do_reset();

    // reset state
    @(negedge clk);
    chk("rst_idle", W'(idle0), W'(1));
    chk("rst_cnt", W'(cnt0), W'(0));
    chk("rst_to_mesh_valid", W'(bus0.to_mesh_valid), W'(0));
    chk("rst_resp_valid", W'(bus0.match_resp_valid), W'(0));
    chk("rst_from_mesh_ready", W'(bus0.from_mesh_ready), W'(1));
    chk("rst_err", W'(err0), W'(0));
    @(posedge clk);
    #1;
    bus0.to_mesh_ready = 1'b1;
    bus0.match_resp_ready = 1'b1;

    // single request to both mapping variants
    set_req(1'b1, 3'd2, 32'h1234_5678, 32'h0000_6000);
    bus1.match_req_valid = 1'b1;
    bus1.match_req_tag = 3'd2;
    bus1.match_req_head_addr = 32'h1234_5678;
    bus1.match_req_history_addr = 32'h0000_6000;
    chk("dense_req_ready", W'(bus1.match_req_ready), W'(1));
    tick();
    chk("single_req_fired", W'(req_fired), W'(1));
    set_req(1'b0, 3'd0, 32'd0, 32'd0);
    bus1.match_req_valid = 1'b0;
    @(negedge clk);
    chk("single_valid_n1", W'(bus0.to_mesh_valid), W'(1));
    chk("single_idle", W'(idle0), W'(0));
    chk("single_cnt", W'(cnt0), W'(1));
    chk("il_x", W'(bus0.to_mesh_x_dst), W'(2'b11));
    chk("il_y", W'(bus0.to_mesh_y_dst), W'(2'b01));
    e1 = model_pkt(32'h1234_5678, 32'h0000_6000, 3'd2, 1'b0);
    chk("dense_valid", W'(bus1.to_mesh_valid), W'(1));
    chk("dense_x", W'(bus1.to_mesh_x_dst), W'(2'b11));
    chk("dense_y", W'(bus1.to_mesh_y_dst), W'(2'b00));
    chk("dense_payload", bus1.to_mesh_payload, e1.payload);
    @(posedge clk);
    #1;
    send_resp(3'd2, 6'd40);

    // tags 0..3 back to back, then the count limit
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 3'(i), $urandom, $urandom);
      tick();
      chk("b2b_fired", W'(req_fired), W'(1));
    end
    set_req(1'b1, 3'd4, 32'hAAAA_0001, 32'h0001_2000);
    tick();
    chk("limit_blocked", W'(req_fired), W'(0));
    send_resp(3'd1, 6'd9);
    tick();
    chk("ready_after_retire", W'(req_fired), W'(1));
    set_req(1'b0, 3'd0, 32'd0, 32'd0);

    // in-flight tag is refused until its response retires it
    send_resp(3'd0, 6'd3);
    set_req(1'b1, 3'd2, 32'h0BAD_F00D, 32'h0000_E000);
    tick();
    chk("inflight_blocked", W'(req_fired), W'(0));
    send_resp(3'd2, 6'd17);
    tick();
    chk("reissue_after_retire", W'(req_fired), W'(1));
    set_req(1'b0, 3'd0, 32'd0, 32'd0);

    // unexpected tag is dropped and flagged
    send_resp(3'd5, 6'd1);
    tick();
    tick();
    chk("err_sticky", W'(err0), W'(1));

    // response backpressure: two buffered, third refused, then in-order drain
    bus0.match_resp_ready = 1'b0;
    send_resp(3'd3, 6'd20);
    send_resp(3'd4, 6'd33);
    bus0.from_mesh_valid = 1'b1;
    bus0.from_mesh_payload = make_resp(3'd2, 6'd45);
    tick();
    chk("bp_third_refused", W'(resp_fired), W'(0));
    chk("bp_from_mesh_ready", W'(bus0.from_mesh_ready), W'(0));
    bus0.match_resp_ready = 1'b1;
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      done = resp_fired;
    end
    chk("bp_third_accepted", W'(done), W'(1));
    bus0.from_mesh_valid = 1'b0;
    tick();
    tick();

    // reset with two requests in flight, then a late response
    set_req(1'b1, 3'd6, $urandom, $urandom);
    tick();
    set_req(1'b1, 3'd7, $urandom, $urandom);
    tick();
    set_req(1'b0, 3'd0, 32'd0, 32'd0);
    tick();
    chk("pre_reset_cnt", W'(cnt0), W'(2));
    do_reset();
    @(negedge clk);
    chk("post_reset_cnt", W'(cnt0), W'(0));
    chk("post_reset_idle", W'(idle0), W'(1));
    chk("post_reset_err", W'(err0), W'(0));
    @(posedge clk);
    #1;
    bus0.to_mesh_ready = 1'b1;
    bus0.match_resp_ready = 1'b1;
    send_resp(3'd6, 6'd5);
    tick();
    chk("late_resp_err", W'(err0), W'(1));

    // randomized traffic
    do_reset();
    strict_ready = 0;
    for (int c = 0; c < 800; c++) begin
      set_req(($urandom % 3) != 0, 3'($urandom % 8), $urandom, $urandom);
      bus0.to_mesh_ready = ($urandom % 4) != 0;
      bus0.match_resp_ready = ($urandom % 4) != 0;
      bus0.from_mesh_valid = 1'b0;
      if (($urandom % 2) != 0) begin
        cand.delete();
        for (int i = 0; i < 8; i++) if (m_inflight[i]) cand.push_back(i);
        if (cand.size() > 0 && ($urandom % 16) != 0) t = 3'(cand[$urandom % cand.size()]);
        else t = 3'($urandom % 8);
        bus0.from_mesh_valid = 1'b1;
        bus0.from_mesh_payload = make_resp(t, 6'($urandom));
      end
      tick();
    end

    // drain everything still in flight
    set_req(1'b0, 3'd0, 32'd0, 32'd0);
    bus0.from_mesh_valid = 1'b0;
    bus0.to_mesh_ready = 1'b1;
    bus0.match_resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (m_inflight[i]) send_resp(3'(i), 6'(i + 10));
    end
    for (int i = 0; i < 8; i++) tick();
    chk("drain_pkt_queue", W'(exp_pkt.size()), W'(0));
    chk("drain_resp_queue", W'(exp_resp.size()), W'(0));
    chk("drain_idle", W'(idle0), W'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
